// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- program counter and instruction-fetch stage.
//
// Sits behind the branch/jump unit. Sequences fetches against a busywait
// instruction memory, honours hazard stalls, squashes on redirects and
// drives the IF/ID pipeline register.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a redirect to a target with [1:0]!=0 loads TRAP_VECTOR and
//               pulses misalign_trap alongside flush_out.
//   undefined : target bits [1:0] are cleared on load, misalign_trap is 0.
//
// Ports:
//   CLK, RESET                  clock (rising edge), async active-high reset
//   Branch_jump_PC_OUT          redirect target
//   branch_jump_mux_signal      redirect request (same-cycle valid)
//   stall                       hazard stall, holds PC and IF/ID
//   imem_busywait, imem_instr   instruction memory handshake / data
//   imem_read, imem_addr        fetch request (combinational)
//   ifid_pc, ifid_pc_plus4,
//   ifid_instr, ifid_valid      IF/ID pipeline register
//   flush_out                   one-cycle pulse on accepted redirect
//   misalign_trap               one-cycle pulse on misaligned redirect
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Branch_jump_PC_OUT,
  input  logic        branch_jump_mux_signal,
  input  logic        stall,
  input  logic        imem_busywait,
  input  logic [31:0] imem_instr,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        flush_out,
  output logic        misalign_trap
);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] tgt;
  logic        tgt_misalign;

`ifdef MISALIGN_TRAP_EN
  assign tgt_misalign = |Branch_jump_PC_OUT[1:0];
  assign tgt          = tgt_misalign ? TRAP_VECTOR : Branch_jump_PC_OUT;
`else
  assign tgt_misalign = 1'b0;
  assign tgt          = {Branch_jump_PC_OUT[31:2], 2'b00};
`endif

  // Both states keep a read outstanding; DRAIN holds the address of the
  // read that was in flight when the redirect arrived so memory sees a
  // stable request until it completes.
  assign imem_read = !RESET;
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (branch_jump_mux_signal && imem_busywait) state_nxt = DRAIN;
      // A further redirect keeps us draining; otherwise leave once the
      // stale read completes.
      DRAIN: if (!branch_jump_mux_signal && !imem_busywait) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc            <= RESET_VECTOR;
      drain_addr    <= 32'h0;
      ifid_pc       <= 32'h0;
      ifid_pc_plus4 <= 32'h0;
      ifid_instr    <= 32'h0;
      ifid_valid    <= 1'b0;
      flush_out     <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      flush_out     <= 1'b0;
      misalign_trap <= 1'b0;
      if (branch_jump_mux_signal) begin
        // Redirect beats stall and memory in either state.
        pc            <= tgt;
        ifid_valid    <= 1'b0;
        flush_out     <= 1'b1;
        misalign_trap <= tgt_misalign;
        if (state == FETCH && imem_busywait) drain_addr <= pc;
      end else if (state == FETCH && !stall) begin
        if (!imem_busywait) begin
          ifid_pc       <= pc;
          ifid_pc_plus4 <= pc + 32'd4;
          ifid_instr    <= imem_instr;
          ifid_valid    <= 1'b1;
          pc            <= pc + 32'd4;
        end else begin
          ifid_valid <= 1'b0;
        end
      end
      // Stall in FETCH: everything holds. DRAIN: data is discarded and
      // ifid_valid is already 0 from the redirect.
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] Branch_jump_PC_OUT = '0;
  logic        branch_jump_mux_signal = 1'b0;
  logic        stall = 1'b0;
  logic        imem_busywait = 1'b0;
  logic [31:0] imem_instr = '0;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
  logic        ifid_valid, flush_out, misalign_trap;

  pc_fetch_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .CLK(CLK), .RESET(RESET),
    .Branch_jump_PC_OUT(Branch_jump_PC_OUT),
    .branch_jump_mux_signal(branch_jump_mux_signal),
    .stall(stall), .imem_busywait(imem_busywait), .imem_instr(imem_instr),
    .imem_read(imem_read), .imem_addr(imem_addr),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .flush_out(flush_out), .misalign_trap(misalign_trap)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr, pc, pc4, instr;
    logic        valid, flush, trap;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors = 0;

  // Reference model: a PC, an optional "stale read still outstanding"
  // marker with its address, and the last instruction handed to decode.
  logic [31:0] m_pc = RV;
  bit          m_draining = 0;
  logic [31:0] m_stale_addr = '0;
  logic [31:0] m_ipc = '0, m_ipc4 = '0, m_instr = '0;
  logic        m_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the current negedge, advance the model, queue the
  // expectation, then move on to the next negedge.
  task automatic cyc(input bit redir, input logic [31:0] tgt, input bit stl,
                     input bit busy, input logic [31:0] instr);
    exp_t e;
    logic [31:0] dest;
    bit mis;
    branch_jump_mux_signal = redir;
    Branch_jump_PC_OUT     = tgt;
    stall                  = stl;
    imem_busywait          = busy;
    imem_instr             = instr;
    e.addr  = m_draining ? m_stale_addr : m_pc;
    e.flush = 0;
    e.trap  = 0;
    mis  = TRAP_EN && (tgt % 4 != 0);
    dest = mis ? TV : (tgt / 4) * 4;
    if (redir) begin
      if (!m_draining && busy) begin
        m_draining   = 1;
        m_stale_addr = m_pc;
      end
      m_pc    = dest;
      m_valid = 0;
      e.flush = 1;
      e.trap  = mis;
    end else if (m_draining) begin
      if (!busy) m_draining = 0;
    end else if (!stl) begin
      if (!busy) begin
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 4;
        m_instr = instr;
        m_valid = 1;
        m_pc    = m_pc + 4;
      end else m_valid = 0;
    end
    e.pc = m_ipc; e.pc4 = m_ipc4; e.instr = m_instr; e.valid = m_valid;
    q.push_back(e);
    @(negedge CLK);
  endtask

  // Monitor: fetch request is sampled mid-cycle, IF/ID just after the edge.
  initial begin
    logic [31:0] a;
    logic        rd;
    bit          have;
    exp_t        e;
    forever begin
      @(negedge CLK);
      #2;
      have = !RESET;
      a  = imem_addr;
      rd = imem_read;
      @(posedge CLK);
      #1;
      if (have && q.size() > 0) begin
        e = q.pop_front();
        chk("imem_read", {31'b0, rd}, 32'd1);
        chk("imem_addr", a, e.addr);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
        chk("ifid_pc", ifid_pc, e.pc);
        chk("ifid_pc_plus4", ifid_pc_plus4, e.pc4);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("flush_out", {31'b0, flush_out}, {31'b0, e.flush});
        chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, e.trap});
      end
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    chk("rst imem_read", {31'b0, imem_read}, 32'd0);
    chk("rst ifid_pc", ifid_pc, 32'd0);
    chk("rst ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst flush_out", {31'b0, flush_out}, 32'd0);
    chk("rst imem_addr", imem_addr, RV);
    RESET = 1'b0;
    // Sequential fetch 0,4 then a 2-cycle stall, then resume at 8.
    cyc(0, 0, 0, 0, NOP);
    cyc(0, 0, 0, 0, NOP);
    cyc(0, 0, 1, 0, NOP);
    cyc(0, 0, 1, 0, NOP);
    cyc(0, 0, 0, 0, NOP);
    // Three busy cycles at pc=0xC, then it lands.
    cyc(0, 0, 0, 1, NOP);
    cyc(0, 0, 0, 1, NOP);
    cyc(0, 0, 0, 1, NOP);
    cyc(0, 0, 0, 0, NOP);
    // Redirect beats a simultaneous stall.
    cyc(1, 32'h40, 1, 0, NOP);
    cyc(0, 0, 0, 0, 32'hDEAD_0001);
    // Redirect while busy: drain the stale read at 0x44 first.
    cyc(1, 32'h80, 0, 1, NOP);
    cyc(0, 0, 0, 1, NOP);
    cyc(0, 0, 1, 1, NOP);
    cyc(0, 0, 1, 0, 32'hBAD0_BAD0);
    cyc(0, 0, 0, 0, 32'h1234_5678);
    // Redirect inside DRAIN, then misaligned target.
    cyc(1, 32'h200, 0, 1, NOP);
    cyc(1, 32'h300, 0, 1, NOP);
    cyc(0, 0, 0, 0, NOP);
    cyc(0, 0, 0, 0, 32'h0000_0300);
    cyc(1, 32'h42, 0, 0, NOP);
    cyc(0, 0, 0, 0, NOP);
    // Wraparound at the top of the address space.
    cyc(1, 32'hFFFF_FFFC, 0, 0, NOP);
    cyc(0, 0, 0, 0, 32'hFFFF_0001);
    cyc(0, 0, 0, 0, 32'h0000_0002);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      cyc($urandom_range(0, 9) == 0, t, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) < 3, $urandom);
    end
    branch_jump_mux_signal = 0;
    stall = 1;
    repeat (2) @(negedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
